// File: rtl/reflex_pkg.sv
// Shared types and constants for the reaction-time game round controller.
package reflex_pkg;

    // Round phases
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GO   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned LFSR_W    = 16;
    localparam int unsigned WAIT_W    = 16;
    localparam int unsigned RES_W     = 14;

    // Right-shifting Fibonacci LFSR for x^16+x^14+x^13+x^11+1: feedback is the
    // XOR of bits 0, 2, 3 and 5, inserted at bit 15.
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {^(cur & LFSR_TAPS), cur[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick divider with synchronous clear.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : forces the count to 0 on the next edge (phase restart)
//   tick : high for one cycle when the count reaches TICK_DIV-1 (decoded from the count register)
module ms_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == CNT_MAX);

    // Free-running 0..TICK_DIV-1 counter
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/reflex_round_ctrl.sv
// One round of the reaction-time game: random hold-off, GO stimulus, and
// reaction measurement in whole ticks.
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a round (accepted in IDLE or DONE)
//   btn          : debounced, synchronous player button
//   led_go       : high while in GO
//   busy         : high in WAIT and GO
//   result_ms    : measured reaction in ticks, held until the next start
//   result_valid : DONE after a legal press
//   foul         : DONE after an early press
//   timeout      : DONE after no press within MAX_REACT_MS ticks
module reflex_round_ctrl
    import reflex_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned MIN_WAIT_MS  = 1000,
    parameter int unsigned RAND_MASK    = 2047,
    parameter int unsigned MAX_REACT_MS = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             btn,
    output logic             led_go,
    output logic             busy,
    output logic [RES_W-1:0] result_ms,
    output logic             result_valid,
    output logic             foul,
    output logic             timeout
);

    // Elaboration-time parameter checks
    if (TICK_DIV < 2) begin : g_chk_div
        $error("TICK_DIV must be >= 2");
    end
    if (MIN_WAIT_MS < 1) begin : g_chk_min
        $error("MIN_WAIT_MS must be >= 1");
    end
    if (MAX_REACT_MS > 16383 || MAX_REACT_MS < 1) begin : g_chk_max
        $error("MAX_REACT_MS must be in 1..16383");
    end
    if (64'(MIN_WAIT_MS) + 64'(RAND_MASK) >= 64'd65536) begin : g_chk_wait
        $error("MIN_WAIT_MS + RAND_MASK must fit in 16 bits");
    end

    localparam logic [WAIT_W-1:0] MIN_WAIT  = WAIT_W'(MIN_WAIT_MS);
    localparam logic [WAIT_W-1:0] WAIT_MASK = WAIT_W'(RAND_MASK);
    localparam logic [RES_W-1:0]  REACT_MAX = RES_W'(MAX_REACT_MS);
    localparam logic [RES_W-1:0]  REACT_TOP = RES_W'(MAX_REACT_MS - 1);

    state_t              state_q, state_d;
    logic                btn_q;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [RES_W-1:0]    react_cnt_q, react_cnt_d;
    logic [RES_W-1:0]    result_d;
    logic                valid_d, foul_d, timeout_d;
    logic                led_go_d, busy_d;
    logic                btn_edge_c;
    logic                tick_clr_c;
    logic                tick;

    assign btn_edge_c = btn & ~btn_q;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr_c),
        .tick (tick)
    );

    // State register, counters, LFSR, button history and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            btn_q        <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            wait_cnt_q   <= '0;
            react_cnt_q  <= '0;
            result_ms    <= '0;
            result_valid <= 1'b0;
            foul         <= 1'b0;
            timeout      <= 1'b0;
            led_go       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_q        <= btn;
            lfsr_q       <= lfsr_next(lfsr_q);
            wait_cnt_q   <= wait_cnt_d;
            react_cnt_q  <= react_cnt_d;
            result_ms    <= result_d;
            result_valid <= valid_d;
            foul         <= foul_d;
            timeout      <= timeout_d;
            led_go       <= led_go_d;
            busy         <= busy_d;
        end
    end

    // Next-state and next-output logic; a press beats a same-cycle tick
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        react_cnt_d = react_cnt_q;
        result_d    = result_ms;
        valid_d     = result_valid;
        foul_d      = foul;
        timeout_d   = timeout;
        tick_clr_c  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = WAIT;
                    wait_cnt_d = MIN_WAIT + (lfsr_q & WAIT_MASK);
                    result_d   = '0;
                    valid_d    = 1'b0;
                    foul_d     = 1'b0;
                    timeout_d  = 1'b0;
                    tick_clr_c = 1'b1;
                end
            end
            WAIT: begin
                if (btn_edge_c) begin
                    state_d  = DONE;
                    foul_d   = 1'b1;
                    result_d = '0;
                end else if (tick) begin
                    if (wait_cnt_q == WAIT_W'(1)) begin
                        state_d     = GO;
                        react_cnt_d = '0;
                        tick_clr_c  = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                    end
                end
            end
            GO: begin
                if (btn_edge_c) begin
                    state_d  = DONE;
                    result_d = react_cnt_q;
                    valid_d  = 1'b1;
                end else if (tick) begin
                    if (react_cnt_q == REACT_TOP) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                        result_d  = REACT_MAX;
                    end else begin
                        react_cnt_d = react_cnt_q + RES_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        led_go_d = (state_d == GO);
        busy_d   = (state_d == WAIT) || (state_d == GO);
    end

endmodule

// File: tb/tb_reflex_round_ctrl.sv
// Directed bench for reflex_round_ctrl with TICK_DIV=4, MIN_WAIT_MS=3,
// MAX_REACT_MS=10; one instance with RAND_MASK=0, one with RAND_MASK=2047.
module tb_reflex_round_ctrl;

    logic clk = 1'b0;
    logic rst, start0, btn0, start1, btn1;

    logic        led_go0, busy0, valid0, foul0, tmo0;
    logic [13:0] res0;
    logic        led_go1, busy1, valid1, foul1, tmo1;
    logic [13:0] res1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reflex_round_ctrl #(
        .TICK_DIV(4), .MIN_WAIT_MS(3), .RAND_MASK(0), .MAX_REACT_MS(10)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start0), .btn(btn0),
        .led_go(led_go0), .busy(busy0), .result_ms(res0),
        .result_valid(valid0), .foul(foul0), .timeout(tmo0)
    );

    reflex_round_ctrl #(
        .TICK_DIV(4), .MIN_WAIT_MS(3), .RAND_MASK(2047), .MAX_REACT_MS(10)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .btn(btn1),
        .led_go(led_go1), .busy(busy1), .result_ms(res1),
        .result_valid(valid1), .foul(foul1), .timeout(tmo1)
    );

    // Reference LFSR: x^16+x^14+x^13+x^11+1, right-shifting, seed ACE1
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    typedef struct {
        int          n;
        logic        rst, start, btn;
        logic        led, busy;
        logic [13:0] res;
        logic        valid, foul, tmo;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs[NV];

    function automatic logic [18:0] pk(logic led, logic bsy, logic [13:0] r,
                                       logic v, logic f, logic t);
        return {led, bsy, r, v, f, t};
    endfunction

    task automatic check(input string nm, input logic [18:0] act, input logic [18:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got led=%b busy=%b res=%0d v=%b f=%b t=%b, expected led=%b busy=%b res=%0d v=%b f=%b t=%b",
                     nm, act[18], act[17], act[16:3], act[2], act[1], act[0],
                     exp[18], exp[17], exp[16:3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [18:0] out0();
        return pk(led_go0, busy0, res0, valid0, foul0, tmo0);
    endfunction

    function automatic logic [18:0] out1();
        return pk(led_go1, busy1, res1, valid1, foul1, tmo1);
    endfunction

    // Hold inputs for n edges; return 1 ns after the last edge
    task automatic apply(input int n, input logic r, input logic s, input logic b);
        rst = r; start0 = s; btn0 = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        logic [15:0] exp_wait;

        rst = 1'b1; start0 = 1'b0; btn0 = 1'b0; start1 = 1'b0; btn1 = 1'b0;

        //            n  rst st btn  led bsy res valid foul tmo
        vecs[0]  = '{ 2, 1, 0, 0,   0, 0, 14'd0,  0, 0, 0};  // reset
        vecs[1]  = '{ 1, 0, 1, 0,   0, 1, 14'd0,  0, 0, 0};  // start -> WAIT
        vecs[2]  = '{11, 0, 0, 0,   0, 1, 14'd0,  0, 0, 0};
        vecs[3]  = '{ 1, 0, 0, 0,   1, 1, 14'd0,  0, 0, 0};  // GO 12 cycles after start
        vecs[4]  = '{ 8, 0, 0, 0,   1, 1, 14'd0,  0, 0, 0};
        vecs[5]  = '{ 1, 0, 0, 1,   0, 0, 14'd2,  1, 0, 0};  // press 9 after GO
        vecs[6]  = '{ 2, 0, 0, 0,   0, 0, 14'd2,  1, 0, 0};  // held in DONE
        vecs[7]  = '{ 1, 0, 0, 1,   0, 0, 14'd2,  1, 0, 0};  // btn ignored in DONE
        vecs[8]  = '{ 1, 0, 1, 0,   0, 1, 14'd0,  0, 0, 0};  // start from DONE clears
        vecs[9]  = '{ 4, 0, 0, 0,   0, 1, 14'd0,  0, 0, 0};
        vecs[10] = '{ 1, 0, 0, 1,   0, 0, 14'd0,  0, 1, 0};  // foul 5 after start
        vecs[11] = '{ 1, 0, 1, 0,   0, 1, 14'd0,  0, 0, 0};  // start clears foul
        vecs[12] = '{11, 0, 0, 0,   0, 1, 14'd0,  0, 0, 0};
        vecs[13] = '{ 1, 0, 0, 0,   1, 1, 14'd0,  0, 0, 0};
        vecs[14] = '{39, 0, 0, 0,   1, 1, 14'd0,  0, 0, 0};
        vecs[15] = '{ 1, 0, 0, 0,   0, 0, 14'd10, 0, 0, 1};  // timeout 40 after GO
        vecs[16] = '{ 1, 1, 0, 0,   0, 0, 14'd0,  0, 0, 0};  // reset from DONE
        vecs[17] = '{ 1, 0, 1, 1,   0, 1, 14'd0,  0, 0, 0};  // btn held from IDLE
        vecs[18] = '{ 4, 0, 0, 1,   0, 1, 14'd0,  0, 0, 0};
        vecs[19] = '{ 1, 0, 1, 1,   0, 1, 14'd0,  0, 0, 0};  // start in WAIT ignored
        vecs[20] = '{ 6, 0, 0, 1,   0, 1, 14'd0,  0, 0, 0};
        vecs[21] = '{ 1, 0, 0, 1,   1, 1, 14'd0,  0, 0, 0};  // GO timing unchanged
        vecs[22] = '{40, 0, 0, 1,   0, 0, 14'd10, 0, 0, 1};  // held btn -> timeout
        vecs[23] = '{ 1, 0, 1, 0,   0, 1, 14'd0,  0, 0, 0};
        vecs[24] = '{12, 0, 0, 0,   1, 1, 14'd0,  0, 0, 0};
        vecs[25] = '{ 3, 0, 0, 0,   1, 1, 14'd0,  0, 0, 0};
        vecs[26] = '{ 1, 1, 0, 0,   0, 0, 14'd0,  0, 0, 0};  // rst during GO
        vecs[27] = '{ 2, 0, 0, 0,   0, 0, 14'd0,  0, 0, 0};  // stays IDLE

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].n, vecs[i].rst, vecs[i].start, vecs[i].btn);
            check($sformatf("vec%0d", i), out0(),
                  pk(vecs[i].led, vecs[i].busy, vecs[i].res,
                     vecs[i].valid, vecs[i].foul, vecs[i].tmo));
        end

        // Tie: press on the final WAIT tick is a foul; GO never seen before it
        apply(1, 0, 1, 0);
        for (int i = 0; i < 11; i++) begin
            apply(1, 0, 0, 0);
            check($sformatf("wait_tie_pre%0d", i), out0(), pk(0, 1, 14'd0, 0, 0, 0));
        end
        apply(1, 0, 0, 1);
        check("wait_tie", out0(), pk(0, 0, 14'd0, 0, 1, 0));

        // Tie: press on the 10th GO tick is a legal press of 9 ticks
        apply(1, 0, 1, 0);
        check("go_tie_start", out0(), pk(0, 1, 14'd0, 0, 0, 0));
        apply(12, 0, 0, 0);
        check("go_tie_go", out0(), pk(1, 1, 14'd0, 0, 0, 0));
        apply(39, 0, 0, 0);
        apply(1, 0, 0, 1);
        check("go_tie", out0(), pk(0, 0, 14'd9, 1, 0, 0));
        apply(1, 0, 0, 0);

        // Random hold-off: GO must arrive (3 + (lfsr & 2047)) * 4 cycles after start
        for (int r = 0; r < 2; r++) begin
            exp_wait = 16'd3 + (m_lfsr & 16'd2047);
            start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            k = 0;
            while (!led_go1 && k < 9000) begin
                @(posedge clk); #1;
                k++;
            end
            n_vec++;
            if (k != 4 * int'(exp_wait)) begin
                n_bad++;
                $display("FAIL lfsr_holdoff%0d: got %0d cycles, expected %0d", r, k, 4 * int'(exp_wait));
            end
            btn1 = 1'b1;
            @(posedge clk); #1;
            btn1 = 1'b0;
            check($sformatf("lfsr_press%0d", r), out1(), pk(0, 0, 14'd0, 1, 0, 0));
            repeat (3) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
